// File: rtl/matram_pkg.sv
// Shared MatRAM constants, word types and writeback FSM state encoding.
package matram_pkg;

    localparam int unsigned ADDR_W = 10;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned DIM_W  = 6;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [DATA_W-1:0] data_t;
    typedef logic [DIM_W-1:0]  dim_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } wb_state_t;

    // A tile with no rows or no columns produces no writes.
    function automatic logic tile_empty(input dim_t rows, input dim_t cols);
        return (rows == '0) || (cols == '0);
    endfunction

endpackage

// File: rtl/matram_wb_addr_gen.sv
// Row/column walker for a strided tile: current write address, last-element
// flag and sticky address-wrap detection.
module matram_wb_addr_gen
    import matram_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              load_i,
    input  logic              adv_i,
    input  logic [ADDR_W-1:0] base_i,
    input  logic [ADDR_W-1:0] stride_i,
    input  logic [DIM_W-1:0]  rows_i,
    input  logic [DIM_W-1:0]  cols_i,
    output logic [ADDR_W-1:0] cur_addr_o,
    output logic              last_o,
    output logic              wrap_err_o
);

    dim_t  rows_q, rows_d, cols_q, cols_d;
    dim_t  row_q, row_d, col_q, col_d;
    addr_t stride_q, stride_d;
    addr_t cur_q, cur_d, rs_q, rs_d;
    logic  wrap_q, wrap_d;

    logic [ADDR_W:0] inc_sum;
    logic [ADDR_W:0] row_sum;
    logic            last_col;
    logic            last_row;

    // Carry-extended sums expose wrap past the top of MatRAM.
    assign inc_sum  = {1'b0, cur_q} + (ADDR_W+1)'(1);
    assign row_sum  = {1'b0, rs_q} + {1'b0, stride_q};
    assign last_col = (col_q == cols_q - DIM_W'(1));
    assign last_row = (row_q == rows_q - DIM_W'(1));

    assign cur_addr_o = cur_q;
    assign last_o     = last_col && last_row;
    assign wrap_err_o = wrap_q;

    // Next-state: load tile geometry on start, step one element per transfer.
    always_comb begin
        rows_d   = rows_q;
        cols_d   = cols_q;
        stride_d = stride_q;
        row_d    = row_q;
        col_d    = col_q;
        cur_d    = cur_q;
        rs_d     = rs_q;
        wrap_d   = wrap_q;
        if (load_i) begin
            rows_d   = rows_i;
            cols_d   = cols_i;
            stride_d = stride_i;
            row_d    = '0;
            col_d    = '0;
            cur_d    = base_i;
            rs_d     = base_i;
            wrap_d   = 1'b0;
        end else if (adv_i) begin
            if (!last_col) begin
                col_d  = col_q + DIM_W'(1);
                cur_d  = inc_sum[ADDR_W-1:0];
                wrap_d = wrap_q | inc_sum[ADDR_W];
            end else begin
                col_d  = '0;
                row_d  = row_q + DIM_W'(1);
                rs_d   = row_sum[ADDR_W-1:0];
                cur_d  = row_sum[ADDR_W-1:0];
                wrap_d = wrap_q | row_sum[ADDR_W];
            end
        end
    end

    // Walker state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rows_q   <= '0;
            cols_q   <= '0;
            stride_q <= '0;
            row_q    <= '0;
            col_q    <= '0;
            cur_q    <= '0;
            rs_q     <= '0;
            wrap_q   <= 1'b0;
        end else begin
            rows_q   <= rows_d;
            cols_q   <= cols_d;
            stride_q <= stride_d;
            row_q    <= row_d;
            col_q    <= col_d;
            cur_q    <= cur_d;
            rs_q     <= rs_d;
            wrap_q   <= wrap_d;
        end
    end

endmodule

// File: rtl/matram_writeback_controller.sv
// Streams MAU results into MatRAM as a strided ROWS x COLS tile through a
// registered write port.
module matram_writeback_controller
    import matram_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              set_address,
    input  logic [ADDR_W-1:0] address_in,
    input  logic [ADDR_W-1:0] row_stride,
    input  logic [DIM_W-1:0]  dim_rows,
    input  logic [DIM_W-1:0]  dim_cols,
    input  logic              wb_start,
    input  logic              res_valid,
    input  logic [DATA_W-1:0] res_data,
    output logic              res_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              busy,
    output logic              wb_done,
    output logic              wrap_err
);

    wb_state_t state_q, state_d;
    addr_t     base_q, base_d;
    logic      mem_we_q, mem_we_d;
    addr_t     mem_addr_q, mem_addr_d;
    data_t     mem_wdata_q, mem_wdata_d;

    logic      start_acc;
    logic      xfer;
    logic      last_elem;
    addr_t     load_base;
    addr_t     cur_addr;

    // A same-cycle set_address overrides the stored base for this tile.
    assign start_acc = (state_q == IDLE) && wb_start;
    assign xfer      = (state_q == WRITE) && res_valid;
    assign load_base = set_address ? address_in : base_q;

    assign res_ready = (state_q == WRITE);
    assign busy      = (state_q != IDLE);
    assign wb_done   = (state_q == DONE);
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

    matram_wb_addr_gen u_addr_gen (
        .clk        (clk),
        .reset      (reset),
        .load_i     (start_acc),
        .adv_i      (xfer),
        .base_i     (load_base),
        .stride_i   (row_stride),
        .rows_i     (dim_rows),
        .cols_i     (dim_cols),
        .cur_addr_o (cur_addr),
        .last_o     (last_elem),
        .wrap_err_o (wrap_err)
    );

    // Next-state and write-port capture.
    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        unique case (state_q)
            IDLE: begin
                if (set_address) begin
                    base_d = address_in;
                end
                if (wb_start) begin
                    state_d = tile_empty(dim_rows, dim_cols) ? DONE : WRITE;
                end
            end
            WRITE: begin
                if (xfer) begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = cur_addr;
                    mem_wdata_d = res_data;
                    if (last_elem) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, base and write-port registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            base_q      <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

endmodule

// File: tb/tb_matram_writeback_controller.sv
// Scoreboard bench for the MatRAM writeback controller.
module tb_matram_writeback_controller;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        set_address = 1'b0;
    logic [9:0]  address_in = '0;
    logic [9:0]  row_stride = '0;
    logic [5:0]  dim_rows = '0;
    logic [5:0]  dim_cols = '0;
    logic        wb_start = 1'b0;
    logic        res_valid = 1'b0;
    logic [15:0] res_data = '0;
    logic        res_ready;
    logic        mem_we;
    logic [9:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic        busy;
    logic        wb_done;
    logic        wrap_err;

    matram_writeback_controller dut (
        .clk         (clk),
        .reset       (reset),
        .set_address (set_address),
        .address_in  (address_in),
        .row_stride  (row_stride),
        .dim_rows    (dim_rows),
        .dim_cols    (dim_cols),
        .wb_start    (wb_start),
        .res_valid   (res_valid),
        .res_data    (res_data),
        .res_ready   (res_ready),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .busy        (busy),
        .wb_done     (wb_done),
        .wrap_err    (wrap_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int a;
        int d;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   total = 0;
    int   bad = 0;
    int   wr_cnt = 0;
    int   m_base = 0;
    int   c0 = 0;

    task automatic chk(input string tag, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Every MatRAM write is matched against the oldest expected write.
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            wr_cnt++;
            if (exp_q.size() == 0) begin
                chk("unexp_write", int'(mem_addr), -1);
            end else begin
                mon_e = exp_q.pop_front();
                chk("wr_addr", int'(mem_addr), mon_e.a);
                chk("wr_data", int'(mem_wdata), mon_e.d);
            end
        end
    end

    // Push the tile's expected writes and pulse wb_start.
    task automatic start_tile(input bit set_a, input int addr, input int rows,
                              input int cols, input int stride, input int d0);
        if (set_a) m_base = addr;
        for (int r = 0; r < rows; r++) begin
            for (int c = 0; c < cols; c++) begin
                exp_q.push_back('{a: (m_base + r * stride + c) % 1024,
                                  d: (d0 + r * cols + c) % 65536});
            end
        end
        @(posedge clk); #1;
        set_address = set_a;
        address_in  = 10'(addr);
        row_stride  = 10'(stride);
        dim_rows    = 6'(rows);
        dim_cols    = 6'(cols);
        wb_start    = 1'b1;
        @(posedge clk); #1;
        wb_start    = 1'b0;
        set_address = 1'b0;
    endtask

    // Offer n elements; optionally toggle valid or poke start/set_address mid-tile.
    task automatic feed(input int n, input int d0, input bit toggle, input int disturb_at);
        int   idx;
        int   cyc;
        logic v;
        logic acc;
        idx = 0;
        cyc = 0;
        while (idx < n && cyc < 200) begin
            v = toggle ? (cyc % 2 == 0) : 1'b1;
            res_valid = v;
            res_data  = 16'(d0 + idx);
            if (idx == disturb_at) begin
                wb_start    = 1'b1;
                set_address = 1'b1;
                address_in  = 10'd100;
            end else begin
                wb_start    = 1'b0;
                set_address = 1'b0;
            end
            @(negedge clk);
            acc = v && res_ready;
            @(posedge clk); #1;
            if (acc) idx++;
            cyc++;
        end
        res_valid   = 1'b0;
        wb_start    = 1'b0;
        set_address = 1'b0;
        if (cyc >= 200) chk("xfer_timeout", idx, n);
    endtask

    // Final write coincides with wb_done; controller is idle one cycle later.
    task automatic check_done(input string tag);
        @(negedge clk);
        chk({tag, "_done"}, int'(wb_done), 1);
        chk({tag, "_busy"}, int'(busy), 1);
        chk({tag, "_last_we"}, int'(mem_we), 1);
        chk({tag, "_rdy_done"}, int'(res_ready), 0);
        @(negedge clk);
        chk({tag, "_idle"}, int'(busy), 0);
        chk({tag, "_done_clr"}, int'(wb_done), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        // Reset state
        #2;
        chk("rst_we", int'(mem_we), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_ready", int'(res_ready), 0);
        chk("rst_addr", int'(mem_addr), 0);
        chk("rst_wrap", int'(wrap_err), 0);
        @(negedge clk);
        reset = 1'b1;

        // 1: base 44, 2x3 stride 8, continuous valid
        c0 = wr_cnt;
        start_tile(1'b1, 44, 2, 3, 8, 1);
        feed(6, 1, 1'b0, -1);
        check_done("t1");
        chk("t1_cnt", wr_cnt - c0, 6);

        // 2: same tile, valid toggling
        c0 = wr_cnt;
        start_tile(1'b0, 0, 2, 3, 8, 11);
        feed(6, 11, 1'b1, -1);
        check_done("t2");
        chk("t2_cnt", wr_cnt - c0, 6);

        // 3: address wrap at the top of MatRAM
        c0 = wr_cnt;
        start_tile(1'b1, 1022, 1, 4, 4, 21);
        chk("t3_wrap_pre", int'(wrap_err), 0);
        feed(4, 21, 1'b0, -1);
        check_done("t3");
        chk("t3_wrap_set", int'(wrap_err), 1);
        repeat (3) @(negedge clk);
        chk("t3_wrap_idle", int'(wrap_err), 1);
        chk("t3_cnt", wr_cnt - c0, 4);

        // 4: empty tile clears wrap_err and never writes
        c0 = wr_cnt;
        start_tile(1'b0, 0, 1, 0, 8, 0);
        @(negedge clk);
        chk("t4_busy", int'(busy), 1);
        chk("t4_done", int'(wb_done), 1);
        chk("t4_ready", int'(res_ready), 0);
        chk("t4_wrap_clr", int'(wrap_err), 0);
        chk("t4_we", int'(mem_we), 0);
        @(negedge clk);
        chk("t4_idle", int'(busy), 0);
        chk("t4_ready2", int'(res_ready), 0);
        chk("t4_cnt", wr_cnt - c0, 0);

        // 5: reset after two writes aborts, base returns to 0
        c0 = wr_cnt;
        start_tile(1'b1, 200, 2, 3, 8, 31);
        feed(2, 31, 1'b0, -1);
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("t5_we", int'(mem_we), 0);
        chk("t5_addr", int'(mem_addr), 0);
        chk("t5_wdata", int'(mem_wdata), 0);
        chk("t5_busy", int'(busy), 0);
        chk("t5_ready", int'(res_ready), 0);
        chk("t5_done", int'(wb_done), 0);
        chk("t5_pre_cnt", wr_cnt - c0, 2);
        exp_q.delete();
        m_base = 0;
        c0 = wr_cnt;
        res_valid = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        repeat (4) @(negedge clk);
        res_valid = 1'b0;
        chk("t5_no_we", wr_cnt - c0, 0);
        start_tile(1'b0, 0, 1, 2, 8, 41);
        feed(2, 41, 1'b0, -1);
        check_done("t5");
        chk("t5_cnt", wr_cnt - c0, 2);

        // 6: start/set_address mid-tile are ignored
        c0 = wr_cnt;
        start_tile(1'b1, 300, 2, 3, 8, 51);
        feed(6, 51, 1'b0, 2);
        check_done("t6");
        start_tile(1'b0, 0, 1, 2, 4, 61);
        feed(2, 61, 1'b0, -1);
        check_done("t6b");
        chk("t6_cnt", wr_cnt - c0, 8);

        repeat (2) @(negedge clk);
        chk("sb_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
